// File: rtl/comp_dest_tx_pkg.sv
// Shared definitions for the compute-unit destination (producer) side.
// Holds the data/slot widths, the destination slot indices and the slot
// state encoding used by dest_slot and comp_dest_tx.
package comp_dest_tx_pkg;

  localparam int unsigned DATA_LEN = 16;
  localparam int unsigned DEST_NUM = 4;

  // Destination slot indices (bit positions in dest_sel / dest_rd / dest_v)
  localparam int unsigned DEST_NEIGH    = 0;
  localparam int unsigned DEST_BUS      = 1;
  localparam int unsigned DEST_INTERIM0 = 2;
  localparam int unsigned DEST_INTERIM1 = 3;

  // One-entry slot occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : comp_dest_tx_pkg

// File: rtl/dest_slot.sv
// One-entry destination register with EMPTY/FULL occupancy.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   wr         : load din this cycle (slot becomes FULL)
//   rd         : consumer read acknowledge (FULL -> EMPTY unless wr)
//   din, dout  : slot data in / registered slot data out
//   v          : slot valid (state == FULL)
//   free       : slot can accept a write this cycle (EMPTY, or FULL being read)
module dest_slot
  import comp_dest_tx_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic                rd,
  input  logic [DATA_LEN-1:0] din,
  output logic [DATA_LEN-1:0] dout,
  output logic                v,
  output logic                free
);

  slot_state_e state_q;
  slot_state_e state_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state: a write wins over a same-cycle read
  always_comb begin
    state_d = state_q;
    if (wr)                         state_d = FULL;
    else if (state_q == FULL && rd) state_d = EMPTY;
  end

  // Data is kept on read; only a write changes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   dout <= '0;
    else if (wr) dout <= din;
  end

  assign v    = (state_q == FULL);
  assign free = (state_q == EMPTY) || rd;

endmodule : dest_slot

// File: rtl/comp_dest_tx.sv
// Producer-side destination logic for a PE: parks each ALU result in the
// selected one-entry destination slots (neighbor, bus, interim0/1), exposes
// their valid flags to consumers and stalls the write-stage instruction while
// any selected slot is still occupied. Multicast writes are all-or-nothing.
// Optional feature macro: COMP_DEST_STALL_CNT_EN adds a saturating stall_cnt.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   inst_valid        : write-stage instruction valid
//   result_v          : ALU result valid
//   result_data       : ALU result
//   dest_sel          : destination select, one bit per slot (multicast ok)
//   dest_rd           : per-slot consumer read acknowledge
//   neigh_data_out    : neighbor slot data
//   bus_data_out      : bus slot data
//   interim_out0/1    : interim slot data
//   dest_v            : per-slot valid
//   stall_cnt         : cycles spent stalled, saturating (feature macro only)
//   inst_stall_dest   : hold write-stage instruction (combinational)
//   commit            : result written this cycle (combinational)
module comp_dest_tx
  import comp_dest_tx_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_valid,
  input  logic                result_v,
  input  logic [DATA_LEN-1:0] result_data,
  input  logic [DEST_NUM-1:0] dest_sel,
  input  logic [DEST_NUM-1:0] dest_rd,
  output logic [DATA_LEN-1:0] neigh_data_out,
  output logic [DATA_LEN-1:0] bus_data_out,
  output logic [DATA_LEN-1:0] interim_out0,
  output logic [DATA_LEN-1:0] interim_out1,
  output logic [DEST_NUM-1:0] dest_v,
`ifdef COMP_DEST_STALL_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  output logic                inst_stall_dest,
  output logic                commit
);

  logic [DEST_NUM-1:0] slot_free;
  logic [DEST_NUM-1:0] slot_wr;
  logic [DATA_LEN-1:0] slot_dout [DEST_NUM];
  logic                req;
  logic                sel_free;

  // Write request and all-selected-slots-free check
  assign req             = inst_valid && result_v && (dest_sel != '0);
  assign sel_free        = &(slot_free | ~dest_sel);
  assign commit          = req && sel_free;
  assign inst_stall_dest = req && !sel_free;
  assign slot_wr         = commit ? dest_sel : '0;

  for (genvar i = 0; i < DEST_NUM; i++) begin : g_slot
    dest_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .wr    (slot_wr[i]),
      .rd    (dest_rd[i]),
      .din   (result_data),
      .dout  (slot_dout[i]),
      .v     (dest_v[i]),
      .free  (slot_free[i])
    );
  end

  assign neigh_data_out = slot_dout[DEST_NEIGH];
  assign bus_data_out   = slot_dout[DEST_BUS];
  assign interim_out0   = slot_dout[DEST_INTERIM0];
  assign interim_out1   = slot_dout[DEST_INTERIM1];

`ifdef COMP_DEST_STALL_CNT_EN
  // Saturating count of stalled cycles; cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     stall_cnt <= '0;
    else if (inst_stall_dest && stall_cnt != '1)   stall_cnt <= stall_cnt + 16'(1);
  end
`endif

endmodule : comp_dest_tx

// File: tb/tb_comp_dest_tx.sv
// Directed self-checking bench for comp_dest_tx.
module tb_comp_dest_tx;
  import comp_dest_tx_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                inst_valid;
  logic                result_v;
  logic [DATA_LEN-1:0] result_data;
  logic [DEST_NUM-1:0] dest_sel;
  logic [DEST_NUM-1:0] dest_rd;
  logic [DATA_LEN-1:0] neigh_data_out;
  logic [DATA_LEN-1:0] bus_data_out;
  logic [DATA_LEN-1:0] interim_out0;
  logic [DATA_LEN-1:0] interim_out1;
  logic [DEST_NUM-1:0] dest_v;
  logic                inst_stall_dest;
  logic                commit;
`ifdef COMP_DEST_STALL_CNT_EN
  logic [15:0]         stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  comp_dest_tx dut (
    .clk             (clk),
    .reset           (reset),
    .inst_valid      (inst_valid),
    .result_v        (result_v),
    .result_data     (result_data),
    .dest_sel        (dest_sel),
    .dest_rd         (dest_rd),
    .neigh_data_out  (neigh_data_out),
    .bus_data_out    (bus_data_out),
    .interim_out0    (interim_out0),
    .interim_out1    (interim_out1),
    .dest_v          (dest_v),
`ifdef COMP_DEST_STALL_CNT_EN
    .stall_cnt       (stall_cnt),
`endif
    .inst_stall_dest (inst_stall_dest),
    .commit          (commit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic rv, input logic [15:0] d,
                       input logic [3:0] sel, input logic [3:0] rd);
    inst_valid  = iv;
    result_v    = rv;
    result_data = d;
    dest_sel    = sel;
    dest_rd     = rd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
    tick();
    chk("rst_dest_v", 32'(dest_v), 32'h0);
    chk("rst_neigh", 32'(neigh_data_out), 32'h0);
    chk("rst_bus", 32'(bus_data_out), 32'h0);
    chk("rst_int0", 32'(interim_out0), 32'h0);
    chk("rst_int1", 32'(interim_out1), 32'h0);
    chk("rst_stall", 32'(inst_stall_dest), 32'h0);
    chk("rst_commit", 32'(commit), 32'h0);
    reset = 1'b0;
    tick();

    // Single write to neighbor
    drive(1'b1, 1'b1, 16'h00A5, 4'b0001, 4'b0000);
    chk("w1_commit", 32'(commit), 32'h1);
    chk("w1_stall", 32'(inst_stall_dest), 32'h0);
    chk("w1_v_before", 32'(dest_v), 32'h0);
    tick();
    chk("w1_dest_v", 32'(dest_v), 32'h1);
    chk("w1_neigh", 32'(neigh_data_out), 32'h00A5);

    // Neighbor full, no read: stall
    drive(1'b1, 1'b1, 16'h00B6, 4'b0001, 4'b0000);
    chk("full_stall", 32'(inst_stall_dest), 32'h1);
    chk("full_commit", 32'(commit), 32'h0);
    tick();
    chk("full_hold_data", 32'(neigh_data_out), 32'h00A5);
    chk("full_hold_v", 32'(dest_v), 32'h1);
    // Read releases the slot in the same cycle
    drive(1'b1, 1'b1, 16'h00B6, 4'b0001, 4'b0001);
    chk("rdw_commit", 32'(commit), 32'h1);
    chk("rdw_stall", 32'(inst_stall_dest), 32'h0);
    tick();
    chk("rdw_neigh", 32'(neigh_data_out), 32'h00B6);
    chk("rdw_v", 32'(dest_v), 32'h1);

    // Read only: slot empties, data retained
    drive(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0001);
    tick();
    chk("rd_empty_v", 32'(dest_v), 32'h0);
    chk("rd_keep_data", 32'(neigh_data_out), 32'h00B6);

    // Result not ready: no stall, no write
    drive(1'b1, 1'b0, 16'h1234, 4'b0001, 4'b0000);
    chk("norv_stall", 32'(inst_stall_dest), 32'h0);
    chk("norv_commit", 32'(commit), 32'h0);
    tick();
    chk("norv_v", 32'(dest_v), 32'h0);
    // No destination selected: no stall, no write
    drive(1'b1, 1'b1, 16'h1234, 4'b0000, 4'b0000);
    chk("nosel_stall", 32'(inst_stall_dest), 32'h0);
    chk("nosel_commit", 32'(commit), 32'h0);
    tick();
    chk("nosel_v", 32'(dest_v), 32'h0);

    // Multicast all-or-nothing: fill bus first
    drive(1'b1, 1'b1, 16'h0011, 4'b0010, 4'b0000);
    tick();
    chk("mc_bus_fill", 32'(dest_v), 32'h2);
    drive(1'b1, 1'b1, 16'h0022, 4'b0110, 4'b0000);
    chk("mc_stall", 32'(inst_stall_dest), 32'h1);
    chk("mc_commit", 32'(commit), 32'h0);
    tick();
    chk("mc_no_partial", 32'(dest_v), 32'h2);
    chk("mc_bus_old", 32'(bus_data_out), 32'h0011);
    drive(1'b1, 1'b1, 16'h0022, 4'b0110, 4'b0010);
    chk("mc_rd_commit", 32'(commit), 32'h1);
    tick();
    chk("mc_both_v", 32'(dest_v), 32'h6);
    chk("mc_bus_new", 32'(bus_data_out), 32'h0022);
    chk("mc_int0_new", 32'(interim_out0), 32'h0022);

    // Drain both
    drive(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0110);
    tick();
    chk("drain_v", 32'(dest_v), 32'h0);

    // Back-to-back bus writes with continuous read
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 16'(k), 4'b0010, 4'b0010);
      chk($sformatf("b2b_stall_%0d", k), 32'(inst_stall_dest), 32'h0);
      tick();
      chk($sformatf("b2b_data_%0d", k), 32'(bus_data_out), 32'(k));
      chk($sformatf("b2b_v_%0d", k), 32'(dest_v), 32'h2);
    end

    // Reset while interim1 is full and a write is stalled
    drive(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0010);
    tick();
    drive(1'b1, 1'b1, 16'h0077, 4'b1000, 4'b0000);
    tick();
    chk("int1_fill_v", 32'(dest_v), 32'h8);
    chk("int1_data", 32'(interim_out1), 32'h0077);
    drive(1'b1, 1'b1, 16'h0088, 4'b1000, 4'b0000);
    chk("pre_rst_stall", 32'(inst_stall_dest), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_v", 32'(dest_v), 32'h0);
    chk("mid_rst_stall", 32'(inst_stall_dest), 32'h0);
    chk("mid_rst_int1", 32'(interim_out1), 32'h0);
    drive(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
    tick();
    reset = 1'b0;
    tick();

`ifdef COMP_DEST_STALL_CNT_EN
    chk("cnt_rst", 32'(stall_cnt), 32'h0);
    drive(1'b1, 1'b1, 16'h0001, 4'b0001, 4'b0000);
    tick();
    chk("cnt_after_commit", 32'(stall_cnt), 32'h0);
    for (int k = 0; k < 5; k++) tick();
    chk("cnt_5", 32'(stall_cnt), 32'h5);
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
    drive(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
    tick();
    chk("cnt_hold", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_comp_dest_tx
